// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: assembles big-endian words from a
// valid/ready byte stream and holds the CPU while loading. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              chk_err
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] WORDS = LEN_W'(1 << ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_FLUSH, S_DONE} state_t;
  logic [31:0] acc;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
  assign chk_err = 1'b0;
`endif

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      shreg;

  logic [LEN_W-1:0] len_clamped;
  logic [31:0]      word_c;
  logic             xfer;
  logic             last_word;

  assign len_clamped = (load_len > WORDS) ? WORDS : load_len;
  assign word_c      = {shreg, rx_data};
  assign xfer        = rx_valid && rx_ready;
  assign last_word   = (word_cnt + LEN_W'(1)) == len_q;

  // rx_ready is registered and cleared on the edge that takes the final byte,
  // so it is already low in the cycle right after that transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      word_cnt  <= '0;
      byte_cnt  <= 2'd0;
      shreg     <= 24'd0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc       <= 32'd0;
      chk_err   <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done     <= 1'b0;
            len_q    <= len_clamped;
            word_cnt <= '0;
            byte_cnt <= 2'd0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc      <= 32'd0;
            chk_err  <= 1'b0;
`endif
            if (len_clamped == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CHECK;
              rx_ready <= 1'b1;
`else
              state    <= S_FLUSH;
`endif
            end else begin
              state    <= S_LOAD;
              rx_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            shreg    <= {shreg[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= word_c;
              mem_addr  <= 32'({word_cnt[ADDR_W-1:0], 2'b00});
              word_cnt  <= word_cnt + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
              acc <= acc + word_c;
              if (last_word) state <= S_CHECK;
`else
              if (last_word) rx_ready <= 1'b0;
`endif
            end
          end else if (!rx_ready) begin
            // final write is on the bus this cycle
            state <= S_FLUSH;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            shreg    <= {shreg[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              chk_err  <= (word_c != acc);
              rx_ready <= 1'b0;
              state    <= S_FLUSH;
            end
          end
        end
`endif
        S_FLUSH: begin
          state    <= S_DONE;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
